// File: rtl/spi_cmd_master.sv
// SPI mode-0 master sending 4-byte command frames (addr MSB, addr LSB, instr, data), one SS window per byte.
// Optional macro SPI_CMD_MASTER_RX_EN enables MISO capture into rsp_data during the data byte.
module spi_cmd_master #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int BYTE_SIZE  = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_addr_msb,
    input  logic [7:0] cmd_addr_lsb,
    input  logic [7:0] cmd_instr,
    input  logic [7:0] cmd_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rsp_data,
    output logic       SCLK,
    output logic       MOSI,
    output logic       SS,
    input  logic       MISO
);
    localparam int HW      = $clog2(CLK_DIV) + 1;
    localparam int GAP_LEN = 2 * CLK_DIV * GAP_CYCLES;
    localparam int GW      = $clog2(GAP_LEN) + 1;
    localparam int BW      = $clog2(BYTE_SIZE);
    localparam logic [HW-1:0] H_LAST   = HW'(CLK_DIV - 1);
    localparam logic [GW-1:0] G_LAST   = GW'(GAP_LEN - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BYTE_SIZE - 1);

    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_HIGH, S_LOW, S_GAP, S_DONE} state_t;

    state_t                   state, state_nxt;
    logic [HW-1:0]            half_cnt;
    logic [GW-1:0]            gap_cnt;
    logic [BW-1:0]            bit_cnt;
    logic [1:0]               byte_idx;
    logic [4*BYTE_SIZE-1:0]   tx_buf;
    logic                     accept, half_end, gap_end, in_byte;

    assign accept   = cmd_valid && cmd_ready;
    assign half_end = (half_cnt == H_LAST);
    assign gap_end  = (gap_cnt == G_LAST);
    assign in_byte  = (state == S_LEAD) || (state == S_HIGH) || (state == S_LOW);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept)   state_nxt = S_LEAD;
            S_LEAD: if (half_end) state_nxt = S_HIGH;
            S_HIGH: if (half_end) state_nxt = S_LOW;
            S_LOW:  if (half_end) state_nxt = (bit_cnt == BIT_LAST) ? S_GAP : S_HIGH;
            S_GAP:  if (gap_end)  state_nxt = (byte_idx == 2'd3) ? S_DONE : S_LEAD;
            S_DONE:               state_nxt = S_IDLE;
            default:              state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        SS        = !in_byte;
        SCLK      = (state == S_HIGH);
        MOSI      = in_byte && tx_buf[4*BYTE_SIZE-1];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= S_IDLE;
            half_cnt <= '0;
            gap_cnt  <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            tx_buf   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                half_cnt <= '0;
            else if (in_byte)
                half_cnt <= half_cnt + HW'(1);
            if (state_nxt != state)
                gap_cnt <= '0;
            else if (state == S_GAP)
                gap_cnt <= gap_cnt + GW'(1);
            if (accept) begin
                tx_buf   <= {cmd_addr_msb, cmd_addr_lsb, cmd_instr, cmd_data};
                bit_cnt  <= '0;
                byte_idx <= '0;
            end else begin
                // MOSI advances on the falling SCLK edge, leaving a full half-period of setup before the next rise.
                if (state == S_HIGH && half_end)
                    tx_buf <= {tx_buf[4*BYTE_SIZE-2:0], 1'b0};
                if (state == S_LOW && half_end)
                    bit_cnt <= bit_cnt + BW'(1);
                if (state == S_GAP && gap_end && byte_idx != 2'd3)
                    byte_idx <= byte_idx + 2'd1;
            end
        end
    end

`ifdef SPI_CMD_MASTER_RX_EN
    logic [7:0] rx_shift;
    logic [7:0] rsp_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_shift <= '0;
            rsp_reg  <= '0;
        end else begin
            // The last eight samples of the frame are the data byte.
            if (state_nxt == S_HIGH && state != S_HIGH)
                rx_shift <= {rx_shift[6:0], MISO};
            if (state == S_DONE)
                rsp_reg <= rx_shift;
        end
    end

    assign rsp_data = rsp_reg;
`else
    logic miso_unused;
    assign miso_unused = MISO;
    assign rsp_data    = 8'h00;
`endif

endmodule

// File: tb/tb_spi_cmd_master.sv
// Directed bench for spi_cmd_master: default timing instance plus a CLK_DIV=1/GAP_CYCLES=1 instance.
module tb_spi_cmd_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec = 0;
    int err = 0;

    logic       cmd_valid = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] a_msb = 8'h00, a_lsb = 8'h00, instr = 8'h00, data = 8'h00;
    logic       v1, v2;
    assign v1 = cmd_valid && !sel;
    assign v2 = cmd_valid && sel;

    logic       ready1, busy1, done1, sclk1, mosi1, ss1, miso1;
    logic [7:0] rsp1;
    logic       ready2, busy2, done2, sclk2, mosi2, ss2, miso2;
    logic [7:0] rsp2;
    assign miso2 = 1'b0;

    spi_cmd_master dut (
        .CLK(clk), .RESET(rst), .cmd_valid(v1), .cmd_ready(ready1),
        .cmd_addr_msb(a_msb), .cmd_addr_lsb(a_lsb), .cmd_instr(instr), .cmd_data(data),
        .busy(busy1), .done(done1), .rsp_data(rsp1),
        .SCLK(sclk1), .MOSI(mosi1), .SS(ss1), .MISO(miso1)
    );

    spi_cmd_master #(.CLK_DIV(1), .GAP_CYCLES(1)) dut_fast (
        .CLK(clk), .RESET(rst), .cmd_valid(v2), .cmd_ready(ready2),
        .cmd_addr_msb(a_msb), .cmd_addr_lsb(a_lsb), .cmd_instr(instr), .cmd_data(data),
        .busy(busy2), .done(done2), .rsp_data(rsp2),
        .SCLK(sclk2), .MOSI(mosi2), .SS(ss2), .MISO(miso2)
    );

    // Monitored signals of whichever instance is selected
    logic ss_w, sclk_w, mosi_w, done_w, ready_w;
    logic [7:0] rsp_w;
    assign ss_w    = sel ? ss2    : ss1;
    assign sclk_w  = sel ? sclk2  : sclk1;
    assign mosi_w  = sel ? mosi2  : mosi1;
    assign done_w  = sel ? done2  : done1;
    assign ready_w = sel ? ready2 : ready1;
    assign rsp_w   = sel ? rsp2   : rsp1;

    // Mode-0 slave: 0xFF on bytes 0-2, 0x3C on byte 3, MSB first, shifting on SCLK fall
    int s_byte = 0;
    int s_bit  = 0;
    logic [7:0] s_val;
    always @(posedge ss1 or negedge sclk1) begin
        if (ss1) begin
            if (s_bit == 8) s_byte = (s_byte + 1) % 4;
            s_bit = 0;
        end else begin
            s_bit++;
        end
    end
    assign s_val = (s_byte == 3) ? 8'h3C : 8'hFF;
    assign miso1 = (s_bit < 8) ? s_val[3'(7 - s_bit)] : 1'b1;

`ifdef SPI_CMD_MASTER_RX_EN
    localparam logic [7:0] RD_EXP = 8'h3C;
`else
    localparam logic [7:0] RD_EXP = 8'h00;
`endif

    int          r_lat, r_falls, r_badwin, r_p2, r_next;
    logic [31:0] r_bits;
    logic [7:0]  r_rsp;

    task automatic run_frame(input logic [31:0] f, input int h, input bit hold);
        int t0, run, last_rise;
        logic pss, psclk;
        @(negedge clk);
        {a_msb, a_lsb, instr, data} = f;
        cmd_valid = 1'b1;
        t0 = cyc;
        r_lat = -1; r_falls = 0; r_badwin = 0; r_bits = '0; r_p2 = 0; r_next = 0; r_rsp = 8'hxx;
        run = 0; last_rise = -1; pss = 1'b1; psclk = 1'b0;
        for (int i = 0; i < 1000 && r_lat < 0; i++) begin
            @(negedge clk);
            if (!hold) cmd_valid = 1'b0;
            else {a_msb, a_lsb, instr, data} = f ^ 32'h5A5A_5A5A ^ i;
            if (pss && !ss_w) begin r_falls++; run = 0; end
            if (!ss_w) run++;
            if (!pss && ss_w && run != 17 * h) r_badwin++;
            if (!psclk && sclk_w) begin
                r_bits = {r_bits[30:0], mosi_w};
                if (last_rise >= 0 && cyc - last_rise == 2) r_p2++;
                last_rise = cyc;
            end
            pss = ss_w; psclk = sclk_w;
            if (done_w) begin r_lat = cyc - t0; r_rsp = rsp_w; end
        end
        if (hold) begin
            @(negedge clk);
            r_next = (ready_w && cmd_valid) ? 1 : 0;
            @(negedge clk);
            cmd_valid = 1'b0;
            for (int i = 0; i < 1000 && !done_w; i++) @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vec++;
        if ({ss1, sclk1, mosi1, ready1, busy1, done1} !== 6'b100100) begin
            err++; $display("FAIL reset_pins got %b want 100100", {ss1, sclk1, mosi1, ready1, busy1, done1});
        end
        vec++;
        if (rsp1 !== 8'h00) begin err++; $display("FAIL reset_rsp got %h want 00", rsp1); end
        vec++;
        if ({ss2, sclk2, ready2, busy2} !== 4'b1010) begin
            err++; $display("FAIL reset_fast got %b want 1010", {ss2, sclk2, ready2, busy2});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write;
        run_frame(32'h1234_01A5, 4, 1'b0);
        vec++; if (r_lat !== 337) begin err++; $display("FAIL write_latency got %0d want 337", r_lat); end
        vec++; if (r_falls !== 4) begin err++; $display("FAIL write_ss_windows got %0d want 4", r_falls); end
        vec++; if (r_badwin !== 0) begin err++; $display("FAIL write_ss_width got %0d bad windows want 0 (68 cycles each)", r_badwin); end
        vec++; if (r_bits !== 32'h1234_01A5) begin err++; $display("FAIL write_mosi got %h want 123401a5", r_bits); end
    endtask

    task automatic test_read;
        run_frame(32'h0010_0200, 4, 1'b0);
        vec++; if (r_rsp !== RD_EXP) begin err++; $display("FAIL read_rsp got %h want %h", r_rsp, RD_EXP); end
        repeat (3) @(negedge clk);
        vec++; if (rsp1 !== RD_EXP || done1 !== 1'b0) begin
            err++; $display("FAIL read_hold got rsp=%h done=%b want rsp=%h done=0", rsp1, done1, RD_EXP);
        end
    endtask

    task automatic test_back_to_back;
        run_frame(32'h2021_015A, 4, 1'b1);
        vec++; if (r_bits !== 32'h2021_015A) begin err++; $display("FAIL hold_payload got %h want 2021015a", r_bits); end
        vec++; if (r_lat !== 337) begin err++; $display("FAIL hold_latency got %0d want 337", r_lat); end
        vec++; if (r_next !== 1) begin err++; $display("FAIL hold_next_accept got %0d want 1", r_next); end
    endtask

    task automatic test_reset_mid;
        int falls, dones;
        logic pss;
        bit found;
        @(negedge clk);
        {a_msb, a_lsb, instr, data} = 32'hDEAD_BEEF;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        falls = 1; pss = 1'b0; found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (pss && !ss1) falls++;
            pss = ss1;
            if (falls == 2 && sclk1) found = 1'b1;
        end
        vec++; if (!found) begin err++; $display("FAIL rst_mid_reach got 0 want 1"); end
        #2 rst = 1'b1;
        #1;
        vec++; if ({ss1, sclk1, busy1, ready1} !== 4'b1001) begin
            err++; $display("FAIL rst_mid_async got %b want 1001", {ss1, sclk1, busy1, ready1});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done1) dones++;
        end
        vec++; if (dones !== 0) begin err++; $display("FAIL rst_mid_no_done got %0d want 0", dones); end
        run_frame(32'h1306_05B6, 4, 1'b0);
        vec++; if (r_lat !== 337) begin err++; $display("FAIL rst_mid_latency got %0d want 337", r_lat); end
        vec++; if (r_bits !== 32'h1306_05B6) begin err++; $display("FAIL rst_mid_mosi got %h want 130605b6", r_bits); end
    endtask

    task automatic test_fast;
        sel = 1'b1;
        run_frame(32'h07A3_09D8, 1, 1'b0);
        vec++; if (r_lat !== 77) begin err++; $display("FAIL fast_latency got %0d want 77", r_lat); end
        vec++; if (r_bits !== 32'h07A3_09D8) begin err++; $display("FAIL fast_mosi got %h want 07a309d8", r_bits); end
        vec++; if (r_p2 !== 28) begin err++; $display("FAIL fast_sclk_period got %0d 2-cycle periods want 28", r_p2); end
        vec++; if (r_falls !== 4 || r_badwin !== 0) begin
            err++; $display("FAIL fast_ss got falls=%0d bad=%0d want falls=4 bad=0", r_falls, r_badwin);
        end
        sel = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_back_to_back;
        test_reset_mid;
        test_fast;
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
